// File: rtl/dec_ctrl_pkg.sv
// Shared types and constants for the receive decimation-chain controller.
package dec_ctrl_pkg;

  localparam int unsigned RATE_LSB = 0;
  localparam int unsigned RATE_W   = 8;
  localparam int unsigned HB1_BIT  = 8;
  localparam int unsigned HB2_BIT  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [RATE_W-1:0] rate;
    logic              hb1_en;
    logic              hb2_en;
  } cfg_t;

  localparam cfg_t RST_CFG = '{rate: 8'd1, hb1_en: 1'b0, hb2_en: 1'b0};

  // Halfband 2 is only meaningful behind halfband 1, so its enable is masked.
  function automatic cfg_t decode_cfg(input logic [HB2_BIT:0] d);
    cfg_t c;
    c.rate   = d[RATE_LSB +: RATE_W];
    c.hb1_en = d[HB1_BIT];
    c.hb2_en = d[HB2_BIT] & d[HB1_BIT];
    return c;
  endfunction

endpackage

// File: rtl/dec_chain_ctrl_if.sv
// Settings-bus, strobe and chain-control signals of the decimation-chain controller.
interface dec_chain_ctrl_if;
  logic        run;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        strobe_in;
  logic        cic_stb;
  logic [7:0]  cic_rate;
  logic        hb1_bypass;
  logic        hb2_bypass;
  logic        chain_rst;
  logic        active;

  modport master (
    output run, set_stb, set_addr, set_data, strobe_in,
    input  cic_stb, cic_rate, hb1_bypass, hb2_bypass, chain_rst, active
  );

  modport slave (
    input  run, set_stb, set_addr, set_data, strobe_in,
    output cic_stb, cic_rate, hb1_bypass, hb2_bypass, chain_rst, active
  );
endinterface

// File: rtl/dec_cfg_reg.sv
// Settings-bus decode: qualifies writes to this block and holds the shadow config.
module dec_cfg_reg
  import dec_ctrl_pkg::*;
#(
  parameter int unsigned SR_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb_i,
  input  logic [7:0]  set_addr_i,
  input  logic [31:0] set_data_i,
  output logic        cfg_wr_o,
  output cfg_t        shadow_o
);

  cfg_t shadow_q, shadow_d;
  logic unused_data;

  assign unused_data = ^set_data_i[31:HB2_BIT+1];

  // A zero rate would never produce an output strobe, so such writes are dropped.
  always_comb begin
    cfg_wr_o = set_stb_i && (set_addr_i == 8'(SR_ADDR))
               && (set_data_i[RATE_LSB +: RATE_W] != '0);
    shadow_d = cfg_wr_o ? decode_cfg(set_data_i[HB2_BIT:0]) : shadow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= RST_CFG;
    else     shadow_q <= shadow_d;
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/dec_chain_ctrl.sv
// Rate controller and sequencer for the CIC + dual-halfband receive decimation chain.
module dec_chain_ctrl
  import dec_ctrl_pkg::*;
#(
  parameter int unsigned SR_ADDR      = 0,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  dec_chain_ctrl_if.slave bus
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  rate_cnt_q, rate_cnt_d;
  logic [7:0]  cic_rate_q, cic_rate_d;
  logic        hb1_byp_q, hb1_byp_d;
  logic        hb2_byp_q, hb2_byp_d;
  logic        cic_stb_q, cic_stb_d;
  logic        chain_rst_q, chain_rst_d;
  logic        active_q, active_d;
  logic        cnt_wrap;
  logic        load_cfg;
  logic        cfg_wr;
  cfg_t        shadow;

  dec_cfg_reg #(
    .SR_ADDR(SR_ADDR)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .set_stb_i  (bus.set_stb),
    .set_addr_i (bus.set_addr),
    .set_data_i (bus.set_data),
    .cfg_wr_o   (cfg_wr),
    .shadow_o   (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      rate_cnt_q  <= '0;
      cic_rate_q  <= RST_CFG.rate;
      hb1_byp_q   <= ~RST_CFG.hb1_en;
      hb2_byp_q   <= ~RST_CFG.hb2_en;
      cic_stb_q   <= 1'b0;
      chain_rst_q <= 1'b1;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      rate_cnt_q  <= rate_cnt_d;
      cic_rate_q  <= cic_rate_d;
      hb1_byp_q   <= hb1_byp_d;
      hb2_byp_q   <= hb2_byp_d;
      cic_stb_q   <= cic_stb_d;
      chain_rst_q <= chain_rst_d;
      active_q    <= active_d;
    end
  end

  // In IDLE a write arriving together with run defers the start by one clock,
  // so the new shadow lands while the chain is still held in reset.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = '0;
    rate_cnt_d  = '0;
    cnt_wrap    = 1'b0;
    load_cfg    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_cfg = 1'b1;
        if (bus.run && !cfg_wr) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.run) begin
          state_d = ST_IDLE;
        end else if (cfg_wr) begin
          state_d = ST_FLUSH;
        end else if (bus.strobe_in) begin
          if (rate_cnt_q == cic_rate_q - 8'd1) cnt_wrap = 1'b1;
          else                                  rate_cnt_d = rate_cnt_q + 8'd1;
        end else begin
          rate_cnt_d = rate_cnt_q;
        end
      end
      ST_FLUSH: begin
        if (!bus.run) begin
          state_d  = ST_IDLE;
          load_cfg = 1'b1;
        end else if (cfg_wr) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d  = ST_RUN;
          load_cfg = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cic_stb_d   = cnt_wrap;
    chain_rst_d = (state_d != ST_RUN);
    active_d    = (state_d == ST_RUN);
    cic_rate_d  = load_cfg ? shadow.rate    : cic_rate_q;
    hb1_byp_d   = load_cfg ? ~shadow.hb1_en : hb1_byp_q;
    hb2_byp_d   = load_cfg ? ~shadow.hb2_en : hb2_byp_q;
  end

  assign bus.cic_stb    = cic_stb_q;
  assign bus.cic_rate   = cic_rate_q;
  assign bus.hb1_bypass = hb1_byp_q;
  assign bus.hb2_bypass = hb2_byp_q;
  assign bus.chain_rst  = chain_rst_q;
  assign bus.active     = active_q;

endmodule

// File: tb/tb_dec_chain_ctrl.sv
// Self-checking bench for dec_chain_ctrl: directed table, corner sequences, random vs model.
module tb_dec_chain_ctrl;

  localparam int unsigned F = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dec_chain_ctrl_if bus ();

  dec_chain_ctrl #(
    .SR_ADDR      (0),
    .FLUSH_CYCLES (F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // {cic_stb, cic_rate, hb1_bypass, hb2_bypass, chain_rst, active}
  function automatic logic [12:0] E(input logic s, input logic [7:0] r, input logic b1,
                                    input logic b2, input logic cr, input logic a);
    return {s, r, b1, b2, cr, a};
  endfunction

  function automatic logic [12:0] outs();
    return {bus.cic_stb, bus.cic_rate, bus.hb1_bypass, bus.hb2_bypass, bus.chain_rst, bus.active};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic [7:0] a,
                       input logic [31:0] d, input logic s);
    bus.run       = r;
    bus.set_stb   = st;
    bus.set_addr  = a;
    bus.set_data  = d;
    bus.strobe_in = s;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: mode 0 idle, 1 run, 2 flush
  int   m_mode, m_left, m_n, m_r, sh_r;
  logic m_h1, m_h2, sh_h1, sh_h2;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_n = 0;
    m_r = 1; m_h1 = 0; m_h2 = 0;
    sh_r = 1; sh_h1 = 0; sh_h2 = 0;
  endtask

  task automatic model_step(input logic r, input logic st, input logic [7:0] a,
                            input logic [31:0] d, input logic s, output logic [12:0] exp);
    logic acc, e_stb;
    acc   = st && (a == 8'h00) && (d[7:0] != 8'h00);
    e_stb = 1'b0;
    case (m_mode)
      0: begin
        m_r = sh_r; m_h1 = sh_h1; m_h2 = sh_h2;
        if (acc) begin sh_r = int'(d[7:0]); sh_h1 = d[8]; sh_h2 = d[9] & d[8]; end
        if (r && !acc) begin m_mode = 1; m_n = 0; end
      end
      1: begin
        if (!r) begin
          if (acc) begin sh_r = int'(d[7:0]); sh_h1 = d[8]; sh_h2 = d[9] & d[8]; end
          m_mode = 0;
        end else if (acc) begin
          sh_r = int'(d[7:0]); sh_h1 = d[8]; sh_h2 = d[9] & d[8];
          m_mode = 2; m_left = F;
        end else if (s) begin
          m_n++;
          if (m_n % m_r == 0) e_stb = 1'b1;
        end
      end
      default: begin
        if (!r) begin
          m_r = sh_r; m_h1 = sh_h1; m_h2 = sh_h2;
          if (acc) begin sh_r = int'(d[7:0]); sh_h1 = d[8]; sh_h2 = d[9] & d[8]; end
          m_mode = 0;
        end else if (acc) begin
          sh_r = int'(d[7:0]); sh_h1 = d[8]; sh_h2 = d[9] & d[8];
          m_left = F;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_r = sh_r; m_h1 = sh_h1; m_h2 = sh_h2;
            m_mode = 1; m_n = 0;
          end
        end
      end
    endcase
    exp = {e_stb, 8'(m_r), !m_h1, !m_h2, (m_mode != 1), (m_mode == 1)};
  endtask

  typedef struct {
    logic        run;
    logic        set_stb;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        strobe;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cnt;
    int hits[$];
    logic        r_run, r_st, r_s;
    logic [7:0]  r_a;
    logic [31:0] r_d;
    logic [12:0] r_exp;

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 32'h0,   1'b1, E(0, 8'd1, 1, 1, 1, 0)};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 32'h0,   1'b1, E(0, 8'd1, 1, 1, 0, 1)};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 32'h0,   1'b1, E(1, 8'd1, 1, 1, 0, 1)};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 32'h0,   1'b0, E(0, 8'd1, 1, 1, 0, 1)};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 32'h0,   1'b1, E(1, 8'd1, 1, 1, 0, 1)};
    vecs[5]  = '{1'b1, 1'b1, 8'h00, 32'h300, 1'b0, E(0, 8'd1, 1, 1, 0, 1)};
    vecs[6]  = '{1'b1, 1'b1, 8'h05, 32'h303, 1'b0, E(0, 8'd1, 1, 1, 0, 1)};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 32'h0,   1'b1, E(1, 8'd1, 1, 1, 0, 1)};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 32'h0,   1'b0, E(0, 8'd1, 1, 1, 1, 0)};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 32'h207, 1'b0, E(0, 8'd1, 1, 1, 1, 0)};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 32'h0,   1'b0, E(0, 8'd7, 1, 1, 1, 0)};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 32'h0,   1'b0, E(0, 8'd7, 1, 1, 0, 1)};

    drive(0, 0, 8'h00, 32'h0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(outs()), 32'(E(0, 8'd1, 1, 1, 1, 0)));
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].run, vecs[i].set_stb, vecs[i].addr, vecs[i].data, vecs[i].strobe);
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Reconfigure in RUN: R=4, both halfbands
    drive(1, 1, 8'h00, 32'h304, 0);
    tick();
    check("flush_enter", 32'({bus.chain_rst, bus.active, bus.cic_rate}), 32'({1'b1, 1'b0, 8'd7}));
    drive(1, 0, 8'h00, 32'h0, 0);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.chain_rst) cnt++;
      else break;
    end
    check("flush_len", 32'(cnt), 32'(F));
    check("cfg_after_flush", 32'(outs()), 32'(E(0, 8'd4, 0, 0, 0, 1)));

    for (int c = 0; c < 60; c++) begin
      drive(1, 0, 8'h00, 32'h0, (c % 3) == 0);
      tick();
      if (bus.cic_stb) hits.push_back(c);
    end
    check("stb_count", 32'(hits.size()), 32'd5);
    if (hits.size() == 5) begin
      check("stb_first", 32'(hits[0]), 32'd9);
      for (int k = 1; k < 5; k++) check($sformatf("stb_gap%0d", k), 32'(hits[k] - hits[k-1]), 32'd12);
    end

    // Flush restart: second write five clocks into the flush
    drive(1, 1, 8'h00, 32'h102, 0);
    tick();
    cnt = bus.chain_rst ? 1 : 0;
    drive(1, 0, 8'h00, 32'h0, 0);
    repeat (4) begin
      tick();
      if (bus.chain_rst) cnt++;
    end
    drive(1, 1, 8'h00, 32'h005, 0);
    tick();
    if (bus.chain_rst) cnt++;
    drive(1, 0, 8'h00, 32'h0, 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.chain_rst) cnt++;
      else break;
    end
    check("restart_len", 32'(cnt), 32'd21);
    check("restart_cfg", 32'(outs()), 32'(E(0, 8'd5, 1, 1, 0, 1)));

    // Write coincident with the wrapping strobe
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h00, 32'h0, 1);
      tick();
      check("pre_wrap_stb", 32'(bus.cic_stb), 32'd0);
    end
    drive(1, 1, 8'h00, 32'h003, 1);
    tick();
    check("wr_vs_strobe", 32'({bus.cic_stb, bus.chain_rst}), 32'({1'b0, 1'b1}));
    drive(1, 0, 8'h00, 32'h0, 0);
    repeat (3) tick();
    drive(0, 0, 8'h00, 32'h0, 0);
    tick();
    check("run_drop_flush", 32'(outs()), 32'(E(0, 8'd3, 1, 1, 1, 0)));

    // Asynchronous reset in the middle of a flush
    drive(1, 0, 8'h00, 32'h0, 0);
    tick();
    check("rerun", 32'(bus.active), 32'd1);
    drive(1, 1, 8'h00, 32'h209, 0);
    tick();
    drive(1, 0, 8'h00, 32'h0, 0);
    repeat (3) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(outs()), 32'(E(0, 8'd1, 1, 1, 1, 0)));
    @(negedge clk);
    drive(0, 0, 8'h00, 32'h0, 0);
    rst = 1'b0;

    // Random traffic against the reference model
    model_reset();
    r_run = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r_run = ~r_run;
      r_st = ($urandom_range(0, 24) == 0);
      r_a  = ($urandom_range(0, 3) == 0) ? 8'h03 : 8'h00;
      r_d  = $urandom;
      r_d[7:0] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      r_s  = $urandom_range(0, 1) == 1;
      drive(r_run, r_st, r_a, r_d, r_s);
      model_step(r_run, r_st, r_a, r_d, r_s, r_exp);
      tick();
      check($sformatf("rand%0d", i), 32'(outs()), 32'(r_exp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_chain_ctrl.md
# dec_chain_ctrl

Rate controller and sequencer for the receive decimation chain (CIC followed by two cascaded short halfband decimators). Decodes a decimation-configuration word from the settings bus. Generates the CIC output strobe and the halfband bypass controls. On every reconfiguration, holds the chain in reset for a fixed flush interval so stale filter state never reaches the output.

## Interface
- SR_ADDR, default 0: settings-bus address this block responds to.
- FLUSH_CYCLES, default 16: clocks `chain_rst` is held during a reconfiguration flush (legal range 2..255).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  chain enable; level-sensitive.
- `set_stb`  in  1  settings-bus write strobe, one clock wide.
- `set_addr`  in  8  settings-bus address.
- `set_data`  in  32  settings-bus data.
  - [7:0]: CIC rate R, valid 1..255.
  - [8]: enable halfband 1.
  - [9]: enable halfband 2.
- `strobe_in`  in  1  input-rate sample strobe (CIC input cadence).
- `cic_stb`  out  1  one pulse per R accepted `strobe_in` pulses.
- `cic_rate`  out  8  active CIC rate.
- `hb1_bypass`  out  1  bypass for halfband stage 1.
- `hb2_bypass`  out  1  bypass for halfband stage 2.
- `chain_rst`  out  1  synchronous reset to CIC and halfbands.
- `active`  out  1  high only in RUN.

## Operation
- Write acceptance: `set_stb & (set_addr == SR_ADDR) & (set_data[7:0] != 0)`. Writes with R = 0 are ignored and do not flush.
- Effective halfband enables: hb1_en = [8]; hb2_en = [9] & [8]. Halfband 2 never runs without halfband 1.
- Bypass outputs are the inverse of the effective enables.
- An accepted write latches into a shadow config {R, hb1_en, hb2_en}. Outputs always reflect the active config, never the shadow.
- Total decimation is R × 2^(hb1_en + hb2_en). The block only reports it through its outputs; it does not compute it.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: `chain_rst` = 1, rate counter = 0, no `cic_stb`. An accepted write copies shadow to active on the next clock. `run` = 1 → RUN.
  - RUN: `chain_rst` = 0, `active` = 1.
    - Each `strobe_in` increments the counter.
    - A strobe arriving with counter == R−1 wraps the counter to 0 and pulses `cic_stb`.
    - An accepted write → FLUSH. `run` = 0 → IDLE.
  - FLUSH: `chain_rst` = 1, counter held at 0, `strobe_in` ignored.
    - A flush counter runs for FLUSH_CYCLES clocks.
    - At expiry, shadow is copied to active, then → RUN if `run`, else → IDLE.
- Simultaneous events:
  - Accepted write and `strobe_in` in the same RUN cycle: the write wins. The strobe is not counted and no `cic_stb` is issued.
  - Accepted write during FLUSH: shadow is overwritten and the flush counter restarts at 0.
  - `run` falling during FLUSH: → IDLE next clock, with the pending shadow applied.
  - `run` = 0 and an accepted write in the same RUN cycle: → IDLE, with the shadow applied.
- Reset (any time, including mid-flush):
  - State IDLE; counters 0.
  - Active and shadow config = {R=1, hb1_en=0, hb2_en=0}.

## Timing
- All outputs are registered.
- Reset values: `cic_stb`=0, `cic_rate`=1, `hb1_bypass`=1, `hb2_bypass`=1, `chain_rst`=1, `active`=0.
- `run` rising at edge n (IDLE): `active`=1 and `chain_rst`=0 after edge n+1.
- `cic_stb` is high for exactly one clock, starting the clock after the qualifying `strobe_in`. With R=1, `cic_stb` mirrors `strobe_in` delayed by one clock.
- Accepted write at edge n in RUN:
  - `chain_rst`=1 and `active`=0 from edge n+1.
  - New `cic_rate` and bypass values appear at edge n+1+FLUSH_CYCLES.
  - `chain_rst` falls at that same edge.
- Bypass and rate outputs change only on the cycle `chain_rst` is high or during IDLE. They never change while `active`=1.

## Structure
- Shared package `dec_ctrl_pkg`:
  - state encodings (IDLE, RUN, FLUSH);
  - `set_data` field positions (RATE_LSB=0, RATE_W=8, HB1_BIT=8, HB2_BIT=9);
  - reset config constants.
- One sub-module, `dec_cfg_reg`: address match, R≠0 qualification, hb2 masking, and the shadow register. It outputs `cfg_wr` and the shadow fields.
- FSM, flush counter, rate counter and output registers live in `dec_chain_ctrl`.

## Test plan
- Reset then `run`=1 with default config and `strobe_in` every clock → `cic_stb` every clock, one cycle late; bypasses both 1; `chain_rst` falls one clock after `run`.
- In RUN, write R=4, [8]=1, [9]=1 → `chain_rst` high exactly 16 clocks. Then `cic_rate`=4 and both bypasses 0, and `cic_stb` fires on every 4th strobe (strobe_in every 3rd clock → `cic_stb` every 12 clocks).
- Write R=0, then write with wrong address → no flush, outputs unchanged. Write [9]=1, [8]=0 → `hb2_bypass` stays 1.
- Second accepted write 5 clocks into a flush → flush restarts; `chain_rst` high 21 clocks total; the second config is applied.
- Accepted write coincident with `strobe_in` at counter R−1 → no `cic_stb` issued. Separately, `run`=0 mid-flush → IDLE next clock with the new config applied.
- Assert `rst` asynchronously mid-flush (between clock edges) → all outputs at reset values immediately, before the next clock edge.
